// File: rtl/mult_arbiter.sv
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter that shares one registered NxN multiplier
//               between two requesters and returns tagged products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Req_valid0,
    input  logic             Req_valid1,
    output logic             Req_ready0,
    output logic             Req_ready1,
    input  logic [N-1:0]     Data_A0,
    input  logic [N-1:0]     Data_B0,
    input  logic [N-1:0]     Data_A1,
    input  logic [N-1:0]     Data_B1,
    output logic [N-1:0]     Mult_A,
    output logic [N-1:0]     Mult_B,
    output logic             Mult_EA,
    output logic             Mult_EB,
    input  logic [2*N-1:0]   Mult_P,
    output logic             Rsp_valid,
    output logic             Rsp_id,
    output logic [2*N-1:0]   Rsp_data,
    output logic             Busy,
    output logic [15:0]      Op_count
);

    logic             grant;
    logic             winner;

    logic             last_grant_q, last_grant_d;
    logic             s1_vld_q,     s1_vld_d;
    logic             s1_id_q,      s1_id_d;
    logic             s2_vld_q,     s2_vld_d;
    logic             s2_id_q,      s2_id_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [2*N-1:0]   rsp_data_q,   rsp_data_d;
    logic [15:0]      op_count_q,   op_count_d;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant  = 1'b0;
        winner = 1'b0;
        if (En && (Req_valid0 || Req_valid1)) begin
            grant = 1'b1;
            if (Req_valid0 && Req_valid1) begin
                winner = ~last_grant_q;
            end else begin
                winner = Req_valid1;
            end
        end
    end

    assign Req_ready0 = grant & ~winner;
    assign Req_ready1 = grant &  winner;
    assign Mult_A     = grant ? (winner ? Data_A1 : Data_A0) : '0;
    assign Mult_B     = grant ? (winner ? Data_B1 : Data_B0) : '0;
    assign Mult_EA    = grant;
    assign Mult_EB    = grant;

    always_comb begin
        last_grant_d = grant ? winner : last_grant_q;
        s1_vld_d     = grant;
        s1_id_d      = winner;
        s2_vld_d     = s1_vld_q;
        s2_id_d      = s1_id_q;
        rsp_valid_d  = s2_vld_q;
        rsp_id_d     = s2_id_q;
        rsp_data_d   = s2_vld_q ? Mult_P : rsp_data_q;
        op_count_d   = op_count_q + 16'(grant);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant_q <= 1'b1;
            s1_vld_q     <= 1'b0;
            s1_id_q      <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            op_count_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_vld_q     <= s1_vld_d;
            s1_id_q      <= s1_id_d;
            s2_vld_q     <= s2_vld_d;
            s2_id_q      <= s2_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            op_count_q   <= op_count_d;
        end
    end

    assign Rsp_valid = rsp_valid_q;
    assign Rsp_id    = rsp_id_q;
    assign Rsp_data  = rsp_data_q;
    assign Op_count  = op_count_q;
    assign Busy      = s1_vld_q | s2_vld_q | rsp_valid_q;

endmodule

`default_nettype wire
